// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller.
// A cache hit returns the instruction one cycle after the request. A miss reads
// the word one byte at a time from memory, assembles it little-endian, and then
// spends one FILL cycle writing it into the icache and presenting it.
// Optional feature: define ICACHE_FILL_EN to use cache_hit_i and enable the fill
// write. Without it, every request is treated as a miss and cache_we_o stays 0.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] cache_raddr_o,
  input  logic              cache_hit_i,
  input  logic [31:0]       cache_inst_i,
  output logic              cache_we_o,
  output logic [ADDR_W-1:0] cache_waddr_o,
  output logic [31:0]       cache_winst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_done_i,
  input  logic [7:0]        mem_byte_i
);

`ifdef ICACHE_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       word;
  logic              hit;

  // Without the fill feature the cache is never trusted, so every request misses.
  assign hit = cache_hit_i & FILL_EN;

  // Next-state selection; flush wins over everything, including a final byte.
  always_comb begin
    // NOTE: assign a default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (req_i && !hit) state_nxt = FETCH;
        FETCH:   if (mem_done_i && cnt == 2'd3) state_nxt = FILL;
        FILL:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register plus the fetch bookkeeping and registered instruction outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      base         <= '0;
      word         <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
    end else if (rdy) begin
      state        <= state_nxt;
      inst_valid_o <= 1'b0;
      if (!flush_i) begin
        unique case (state)
          IDLE: begin
            if (req_i && hit) begin
              inst_valid_o <= 1'b1;
              inst_o       <= cache_inst_i;
            end else if (req_i) begin
              base <= pc_i;
              cnt  <= 2'd0;
            end
          end
          FETCH: begin
            if (mem_done_i) begin
              word[8*cnt +: 8] <= mem_byte_i;
              cnt              <= cnt + 2'd1;
              if (cnt == 2'd3) begin
                // The pulse lands in the FILL cycle together with the cache write.
                inst_valid_o <= 1'b1;
                inst_o       <= {mem_byte_i, word[23:0]};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o        = (state != IDLE);
  assign cache_raddr_o = pc_i;
  assign mem_req_o     = (state == FETCH) && rdy;
  assign mem_addr_o    = base + ADDR_W'(cnt);
  // The write is withheld while stalled, on a flush, and on a reset in FILL.
  assign cache_we_o    = FILL_EN && (state == FILL) && rdy && !flush_i && !rst;
  assign cache_waddr_o = base;
  assign cache_winst_o = word;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios with literal
// expectations, followed by randomized traffic checked against a
// transaction-level model (a byte queue for the in-flight miss).
module tb_inst_fetch_ctrl;
  localparam int ADDR_W = 32;

`ifdef ICACHE_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              req_i = 1'b0;
  logic [ADDR_W-1:0] pc_i = '0;
  logic              flush_i = 1'b0;
  logic              inst_valid_o;
  logic [31:0]       inst_o;
  logic              busy_o;
  logic [ADDR_W-1:0] cache_raddr_o;
  logic              cache_hit_i = 1'b0;
  logic [31:0]       cache_inst_i = '0;
  logic              cache_we_o;
  logic [ADDR_W-1:0] cache_waddr_o;
  logic [31:0]       cache_winst_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_done_i = 1'b0;
  logic [7:0]        mem_byte_i = '0;

  int checks = 0;
  int failures = 0;

  inst_fetch_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .pc_i(pc_i),
    .flush_i(flush_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o),
    .busy_o(busy_o), .cache_raddr_o(cache_raddr_o), .cache_hit_i(cache_hit_i),
    .cache_inst_i(cache_inst_i), .cache_we_o(cache_we_o),
    .cache_waddr_o(cache_waddr_o), .cache_winst_o(cache_winst_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_done_i(mem_done_i),
    .mem_byte_i(mem_byte_i)
  );

  always #5 clk = ~clk;

  // Reference model: a miss in progress is a queue of bytes received so far.
  bit                m_fetching;
  bit                m_filling;
  logic [7:0]        m_bytes[$];
  logic [ADDR_W-1:0] m_base;
  bit                m_valid;
  logic [31:0]       m_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] assembled();
    return {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
  endfunction

  // Advance the model by one clock edge using the inputs the DUT samples.
  task automatic model_edge();
    if (rst) begin
      m_fetching = 0; m_filling = 0; m_bytes.delete();
      m_base = '0; m_valid = 0; m_inst = '0;
    end else if (rdy) begin
      m_valid = 0;
      if (flush_i) begin
        m_fetching = 0; m_filling = 0;
      end else if (m_filling) begin
        m_filling = 0;
      end else if (m_fetching) begin
        if (mem_done_i) begin
          m_bytes.push_back(mem_byte_i);
          if (m_bytes.size() == 4) begin
            m_fetching = 0; m_filling = 1;
            m_valid = 1; m_inst = assembled();
          end
        end
      end else if (req_i) begin
        if (FILL_EN && cache_hit_i) begin
          m_valid = 1; m_inst = cache_inst_i;
        end else begin
          m_base = pc_i; m_bytes.delete(); m_fetching = 1;
        end
      end
    end
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic compare();
    check("inst_valid_o", {31'd0, inst_valid_o}, {31'd0, m_valid});
    check("inst_o", inst_o, m_inst);
    check("busy_o", {31'd0, busy_o}, {31'd0, m_fetching | m_filling});
    check("mem_req_o", {31'd0, mem_req_o}, {31'd0, m_fetching & rdy});
    check("cache_we_o", {31'd0, cache_we_o},
          {31'd0, FILL_EN & m_filling & rdy & ~flush_i & ~rst});
    check("cache_raddr_o", cache_raddr_o, pc_i);
    if (m_fetching)
      check("mem_addr_o", mem_addr_o, m_base + ADDR_W'(m_bytes.size()));
    if (m_filling) begin
      check("cache_waddr_o", cache_waddr_o, m_base);
      check("cache_winst_o", cache_winst_o, assembled());
    end
  endtask

  // One clock: check mid-cycle, then step the model on the edge.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle_inputs();
    req_i = 0; flush_i = 0; mem_done_i = 0; cache_hit_i = 0; rdy = 1;
  endtask

  task automatic start_miss(input logic [31:0] pc);
    req_i = 1; pc_i = pc; cache_hit_i = 0;
    tick();
    req_i = 0;
  endtask

  task automatic feed_byte(input logic [7:0] b);
    mem_done_i = 1; mem_byte_i = b;
    tick();
    mem_done_i = 0;
  endtask

  initial begin
    logic [7:0] fill_bytes[4];
    fill_bytes = '{8'h93, 8'h00, 8'h10, 8'h00};

    // Reset state
    rst = 1; tick(); tick();
    rst = 0; #1;
    check("rst valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst inst", inst_o, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst cache_we", {31'd0, cache_we_o}, 32'd0);

    // Hit (or, without fill support, a forced miss)
    req_i = 1; pc_i = 32'h100; cache_hit_i = 1; cache_inst_i = 32'h0000_0013;
    tick();
    req_i = 0; cache_hit_i = 0;
    if (FILL_EN) begin
      check("hit valid", {31'd0, inst_valid_o}, 32'd1);
      check("hit inst", inst_o, 32'h0000_0013);
      check("hit mem_req", {31'd0, mem_req_o}, 32'd0);
    end else begin
      check("cfg busy", {31'd0, busy_o}, 32'd1);
      check("cfg mem_addr", mem_addr_o, 32'h100);
      check("cfg cache_we", {31'd0, cache_we_o}, 32'd0);
      flush_i = 1; tick(); flush_i = 0;
    end
    tick();

    // Miss and fill at 0x200
    start_miss(32'h200);
    for (int i = 0; i < 4; i++) begin
      check("miss mem_addr", mem_addr_o, 32'h200 + 32'(i));
      feed_byte(fill_bytes[i]);
    end
    check("fill cache_we", {31'd0, cache_we_o}, {31'd0, FILL_EN});
    check("fill waddr", cache_waddr_o, 32'h200);
    check("fill winst", cache_winst_o, 32'h0010_0093);
    check("fill valid", {31'd0, inst_valid_o}, 32'd1);
    check("fill inst", inst_o, 32'h0010_0093);
    tick();
    check("after fill busy", {31'd0, busy_o}, 32'd0);

    // Flush after the second byte
    start_miss(32'h300);
    feed_byte(8'hAA); feed_byte(8'hBB);
    flush_i = 1; mem_done_i = 1; tick(); flush_i = 0; mem_done_i = 0;
    check("flush busy", {31'd0, busy_o}, 32'd0);
    check("flush mem_req", {31'd0, mem_req_o}, 32'd0);
    check("flush valid", {31'd0, inst_valid_o}, 32'd0);
    check("flush cache_we", {31'd0, cache_we_o}, 32'd0);

    // Stall for 5 cycles mid-fetch with stray completions
    start_miss(32'h400);
    feed_byte(8'h11);
    rdy = 0; mem_done_i = 1; mem_byte_i = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall mem_req", {31'd0, mem_req_o}, 32'd0);
      check("stall mem_addr", mem_addr_o, 32'h401);
    end
    rdy = 1; mem_done_i = 0; #1;
    check("resume mem_addr", mem_addr_o, 32'h401);
    check("resume mem_req", {31'd0, mem_req_o}, 32'd1);
    feed_byte(8'h22); feed_byte(8'h33); feed_byte(8'h44);
    check("resume inst", inst_o, 32'h4433_2211);
    tick();

    // Address wrap
    start_miss(32'hFFFF_FFFE);
    check("wrap addr0", mem_addr_o, 32'hFFFF_FFFE); feed_byte(8'h01);
    check("wrap addr1", mem_addr_o, 32'hFFFF_FFFF); feed_byte(8'h02);
    check("wrap addr2", mem_addr_o, 32'h0000_0000); feed_byte(8'h03);
    check("wrap addr3", mem_addr_o, 32'h0000_0001); feed_byte(8'h04);
    check("wrap inst", inst_o, 32'h0403_0201);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      rdy          = ($urandom_range(0, 9) != 0);
      flush_i      = ($urandom_range(0, 24) == 0);
      req_i        = $urandom_range(0, 1) == 1;
      pc_i         = $urandom;
      cache_hit_i  = $urandom_range(0, 1) == 1;
      cache_inst_i = $urandom;
      mem_done_i   = ($urandom_range(0, 4) < 2);
      mem_byte_i   = 8'($urandom);
      tick();
    end
    rst = 0;
    set_idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the width of every address port.
REQ-002 Port clk  in  1: the single clock, and every state change SHALL occur on its rising edge.
REQ-003 Port rst  in  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port rdy  in  1: global enable; when low, all state and registered outputs SHALL hold.
REQ-005 Port req_i  in  1: fetch request from the IF stage, sampled with pc_i.
REQ-006 Port pc_i  in  ADDR_W: byte address of the requested instruction.
REQ-007 Port flush_i  in  1: abort any fetch in progress (branch redirect).
REQ-008 Port inst_valid_o  out  1: one-cycle pulse marking that inst_o is valid.
REQ-009 Port inst_o  out  32: fetched instruction.
REQ-010 Port busy_o  out  1: high whenever the state is not IDLE.
REQ-011 Port cache_raddr_o  out  ADDR_W: icache read address, driven combinationally from pc_i.
REQ-012 Port cache_hit_i  in  1, and port cache_inst_i  in  32: combinational icache lookup result.
REQ-013 Port cache_we_o  out  1, port cache_waddr_o  out  ADDR_W, and port cache_winst_o  out  32: icache fill write.
REQ-014 Port mem_req_o  out  1, and port mem_addr_o  out  ADDR_W: byte read request to the memory arbiter.
REQ-015 Port mem_done_i  in  1, and port mem_byte_i  in  8: one-cycle completion pulse carrying the requested byte.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, FETCH and FILL.
REQ-017 In IDLE, when rdy, req_i and cache_hit_i are all high, the block SHALL pulse inst_valid_o on the next cycle with inst_o = cache_inst_i, giving a hit latency of 1, and SHALL stay in IDLE.
REQ-018 In IDLE, when rdy and req_i are high and cache_hit_i is low, the block SHALL latch pc_i into base, clear byte counter cnt[1:0], and go to FETCH.
REQ-019 In FETCH, the block SHALL hold mem_req_o high with mem_addr_o = base + cnt (ADDR_W-bit addition, wrapping modulo 2^ADDR_W).
REQ-020 On each mem_done_i in FETCH, the block SHALL store mem_byte_i into word[8*cnt+7:8*cnt] (little-endian) and increment cnt.
REQ-021 On the mem_done_i with cnt = 3, the block SHALL go to FILL.
REQ-022 mem_done_i SHALL be ignored outside FETCH.
REQ-023 In FILL, for exactly one cycle, the block SHALL drive cache_we_o = 1, cache_waddr_o = base and cache_winst_o = the assembled word.
REQ-024 In the same FILL cycle, the block SHALL pulse inst_valid_o with inst_o = the assembled word, then return to IDLE.
REQ-025 req_i and pc_i SHALL be ignored while the state is not IDLE.
REQ-026 flush_i high with rdy high SHALL force IDLE on the next edge from any state, with priority over mem_done_i.
REQ-027 On flush_i, the block SHALL drop mem_req_o on that next edge, suppress any cache write, and suppress any inst_valid_o pulse that edge would have produced.
REQ-028 A req_i hit arriving in the same cycle as flush_i SHALL NOT produce inst_valid_o.
REQ-029 While rdy is low, mem_req_o and cache_we_o SHALL be held low, and state, cnt, base and word SHALL be frozen.
REQ-030 inst_o SHALL hold its last value when inst_valid_o is low.

Reset
REQ-031 On reset, the state SHALL be IDLE, and cnt, base and word SHALL be 0.
REQ-032 On reset, inst_valid_o, inst_o, cache_we_o, mem_req_o and busy_o SHALL be 0.
REQ-033 Reset SHALL take priority over rdy and flush_i.
REQ-034 Reset asserted mid-FETCH or mid-FILL SHALL abandon the fetch with no cache write.

Configuration
REQ-035 With macro ICACHE_FILL_EN defined, the block SHALL use cache_hit_i and perform the FILL write as specified above.
REQ-036 With ICACHE_FILL_EN undefined, the block SHALL treat cache_hit_i as 0, so every request goes to FETCH.
REQ-037 With ICACHE_FILL_EN undefined, cache_we_o SHALL be held at 0, while FILL still pulses inst_valid_o.

Verification
REQ-038 Hit test: stimulus req_i=1, pc_i=0x100, cache_hit_i=1, cache_inst_i=0x00000013 -> required response inst_valid_o=1 with inst_o=0x00000013 on the next cycle, and mem_req_o stays 0.
REQ-039 Miss/fill test: miss at pc_i=0x200, then bytes 0x93,0x00,0x10,0x00 on mem_addr_o 0x200..0x203 -> required response cache_we_o=1, cache_waddr_o=0x200, cache_winst_o=0x00100093, inst_valid_o=1.
REQ-040 Flush test: flush_i asserted after the 2nd byte of a miss -> required response IDLE next cycle, mem_req_o=0, and neither cache_we_o nor inst_valid_o asserted.
REQ-041 rdy test: rdy=0 for 5 cycles mid-FETCH with mem_done_i pulses -> required response cnt and word unchanged, mem_req_o=0, and the fetch resumes at the same byte address afterward.
REQ-042 Wrap test: miss at pc_i=0xFFFFFFFE -> required response mem_addr_o sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-043 Config test: with ICACHE_FILL_EN undefined, cache_hit_i=1 -> required response the block still enters FETCH, and cache_we_o is never asserted.
